// File: rtl/ptmch_pkg.sv
// rtl/ptmch_pkg.sv - shared types, defaults and slice helpers for the opcode-match trigger generator
package ptmch_pkg;

    localparam int OPC_W_DEF  = 12;
    localparam int NUM_CH_DEF = 5;
    localparam int PLS_W_DEF  = 16;
    localparam int CNT_W_DEF  = 8;

    // Sized for the widest legal opcode (16 bits) and longest pulse (255 cycles)
    localparam int BIT_CNT_W = 5;
    localparam int PLS_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EVAL,
        ST_PULSE,
        ST_WAIT_CS
    } ptmch_state_t;

    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/ptmch_sync.sv
// rtl/ptmch_sync.sv - two-flop synchronizer with selectable reset value
module ptmch_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            dout <= RST_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/ptmch_trg_gen2.sv
// rtl/ptmch_trg_gen2.sv - snoops SPI opcodes and fires per-channel trigger pulses on masked matches
module ptmch_trg_gen2
    import ptmch_pkg::*;
#(
    parameter int OPC_W  = OPC_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int PLS_W  = PLS_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                      CLK160M,
    input  logic                      RESET_N,
    input  logic                      SPI_CS,
    input  logic                      SPI_CLK,
    input  logic                      SPI_MOSI,
    input  logic [NUM_CH-1:0]         CFG_EN,
    input  logic [NUM_CH*OPC_W-1:0]   CFG_OPC,
    input  logic [NUM_CH*OPC_W-1:0]   CFG_MASK,
    input  logic                      CNT_CLR,
    output logic [NUM_CH-1:0]         TRG_PLS,
    output logic [NUM_CH*CNT_W-1:0]   HIT_CNT,
    output logic                      BUSY
);

    ptmch_state_t state, state_nxt;

    logic                 cs_s, clk_s, mosi_s;
    logic                 cs_d, clk_d;
    logic [1:0]           sync_fill;
    logic                 armed;
    logic                 cs_fall, clk_rise;
    logic                 last_bit, pls_done;
    logic [OPC_W-1:0]     shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [PLS_CNT_W-1:0] pls_cnt;
    logic [NUM_CH-1:0]    hit;

    ptmch_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk   (CLK160M),
        .rst_n (RESET_N),
        .din   (SPI_CS),
        .dout  (cs_s)
    );

    ptmch_sync #(.RST_VAL(1'b0)) u_sync_clk (
        .clk   (CLK160M),
        .rst_n (RESET_N),
        .din   (SPI_CLK),
        .dout  (clk_s)
    );

    ptmch_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk   (CLK160M),
        .rst_n (RESET_N),
        .din   (SPI_MOSI),
        .dout  (mosi_s)
    );

    // The CS synchronizer comes out of reset reading 1; arm frame detection only once a
    // real CS-high has propagated, so a frame already running at release is ignored.
    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            cs_d      <= 1'b1;
            clk_d     <= 1'b0;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            cs_d      <= cs_s;
            clk_d     <= clk_s;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign cs_fall  = armed && cs_d && !cs_s;
    assign clk_rise = clk_s && !clk_d;
    assign last_bit = (bit_cnt == BIT_CNT_W'(OPC_W - 1));
    assign pls_done = (pls_cnt == PLS_CNT_W'(PLS_W - 1));

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = CFG_EN[i] &&
                     (((shreg ^ CFG_OPC[ch_lsb(i, OPC_W) +: OPC_W]) &
                       CFG_MASK[ch_lsb(i, OPC_W) +: OPC_W]) == '0);
        end
    end

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        BUSY      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_s) begin
                    state_nxt = ST_IDLE;
                end else if (clk_rise && last_bit) begin
                    state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_nxt = (|hit) ? ST_PULSE : ST_WAIT_CS;
            end
            ST_PULSE: begin
                if (pls_done) begin
                    state_nxt = ST_WAIT_CS;
                end
            end
            ST_WAIT_CS: begin
                if (cs_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            shreg   <= '0;
            bit_cnt <= '0;
            pls_cnt <= '0;
            TRG_PLS <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (!cs_s && clk_rise) begin
                        shreg   <= {shreg[OPC_W-2:0], mosi_s};
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    TRG_PLS <= hit;
                    pls_cnt <= '0;
                end
                ST_PULSE: begin
                    if (pls_done) begin
                        TRG_PLS <= '0;
                    end else begin
                        pls_cnt <= pls_cnt + PLS_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge CLK160M or negedge RESET_N) begin
            if (!RESET_N) begin
                cnt <= '0;
            end else if (CNT_CLR) begin
                cnt <= '0;
            end else if (state == ST_EVAL && hit[i] && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign HIT_CNT[ch_lsb(i, CNT_W) +: CNT_W] = cnt;
    end

endmodule

// File: tb/tb_ptmch_trg_gen2.sv
// tb/tb_ptmch_trg_gen2.sv - table-driven scoreboard bench for ptmch_trg_gen2
`timescale 1ns/1ps
module tb_ptmch_trg_gen2;

    localparam int NCH = 5;
    localparam int OW  = 12;

    logic             CLK160M = 1'b0;
    logic             RESET_N = 1'b0;
    logic             SPI_CS = 1'b1;
    logic             SPI_CLK = 1'b0;
    logic             SPI_MOSI = 1'b0;
    logic [NCH-1:0]   CFG_EN = '1;
    logic [NCH*OW-1:0] CFG_OPC  = {12'h01B, 12'h130, 12'hD80, 12'h050, 12'h100};
    logic [NCH*OW-1:0] CFG_MASK = {12'hE1F, 12'hFFF, 12'hFFF, 12'hF5F, 12'hFFF};
    logic             CNT_CLR = 1'b0;
    logic [NCH-1:0]   TRG_PLS;
    logic [NCH*8-1:0] HIT_CNT;
    logic             BUSY;
    logic [NCH-1:0]   TRG_PLS2;
    logic [NCH*2-1:0] HIT_CNT2;
    logic             BUSY2;

    always #3 CLK160M = ~CLK160M;

    ptmch_trg_gen2 dut (
        .CLK160M (CLK160M), .RESET_N (RESET_N),
        .SPI_CS (SPI_CS), .SPI_CLK (SPI_CLK), .SPI_MOSI (SPI_MOSI),
        .CFG_EN (CFG_EN), .CFG_OPC (CFG_OPC), .CFG_MASK (CFG_MASK),
        .CNT_CLR (CNT_CLR), .TRG_PLS (TRG_PLS), .HIT_CNT (HIT_CNT), .BUSY (BUSY)
    );

    ptmch_trg_gen2 #(.CNT_W(2)) dut2 (
        .CLK160M (CLK160M), .RESET_N (RESET_N),
        .SPI_CS (SPI_CS), .SPI_CLK (SPI_CLK), .SPI_MOSI (SPI_MOSI),
        .CFG_EN (CFG_EN), .CFG_OPC (CFG_OPC), .CFG_MASK (CFG_MASK),
        .CNT_CLR (CNT_CLR), .TRG_PLS (TRG_PLS2), .HIT_CNT (HIT_CNT2), .BUSY (BUSY2)
    );

    typedef struct {
        logic [NCH-1:0] trg;
        int             len;
    } exp_t;

    typedef struct {
        logic [31:0]    bits;
        int             nbits;
        logic [NCH-1:0] exp_trg;
        string          name;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   m8[NCH];
    int   m2[NCH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH*8-1:0] pack8();
        logic [NCH*8-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*8 +: 8] = 8'(m8[i]);
        return v;
    endfunction

    function automatic logic [NCH*2-1:0] pack2();
        logic [NCH*2-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*2 +: 2] = 2'(m2[i]);
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) begin
            m8[i] = 0;
            m2[i] = 0;
        end
    endtask

    task automatic expect_pulse(input logic [NCH-1:0] trg, input int len);
        exp_t e;
        e.trg = trg;
        e.len = len;
        sb.push_back(e);
        for (int i = 0; i < NCH; i++) begin
            if (trg[i]) begin
                if (m8[i] < 255) m8[i]++;
                if (m2[i] < 3) m2[i]++;
            end
        end
    endtask

    // Caller is at a falling CLK160M edge; SPI clock phases are 4 system cycles each.
    // With clr set, CNT_CLR is raised for exactly the cycle the FSM spends in EVAL.
    task automatic spi_bit(input logic b, input bit clr);
        SPI_MOSI = b;
        repeat (4) @(negedge CLK160M);
        SPI_CLK = 1'b1;
        if (clr) begin
            repeat (3) @(negedge CLK160M);
            CNT_CLR = 1'b1;
            @(negedge CLK160M);
            CNT_CLR = 1'b0;
        end else begin
            repeat (4) @(negedge CLK160M);
        end
        SPI_CLK = 1'b0;
    endtask

    task automatic spi_frame(input logic [31:0] bits, input int n, input bit raise_cs, input bit clr_last);
        SPI_CS = 1'b0;
        repeat (4) @(negedge CLK160M);
        for (int i = 0; i < n; i++) spi_bit(bits[31-i], clr_last && (i == n - 1));
        repeat (4) @(negedge CLK160M);
        if (raise_cs) SPI_CS = 1'b1;
    endtask

    task automatic settle_and_check(input string name);
        repeat (40) @(negedge CLK160M);
        check({name, "_busy"}, BUSY, 0);
        check({name, "_cnt8"}, HIT_CNT, pack8());
        check({name, "_cnt2"}, HIT_CNT2, pack2());
        check({name, "_pending"}, sb.size(), 0);
    endtask

    // Scoreboard side: measure each pulse and match it against the oldest expectation
    initial begin
        logic [NCH-1:0] pat;
        int             len;
        exp_t           e;
        forever begin
            @(negedge CLK160M);
            if (TRG_PLS != '0) begin
                pat = TRG_PLS;
                len = 0;
                check("pulse_dut2_match", TRG_PLS2, pat);
                while (TRG_PLS == pat && len < 1000) begin
                    len++;
                    @(negedge CLK160M);
                end
                if (sb.size() == 0) begin
                    check("unexpected_pulse", pat, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_pattern", pat, e.trg);
                    check("pulse_length", len, e.len);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   k;
        logic [31:0] w;

        tbl[0] = '{bits: 32'h1001_0010, nbits: 32, exp_trg: 5'b00001, name: "f100_extra"};
        tbl[1] = '{bits: 32'h0F00_0000, nbits: 12, exp_trg: 5'b00010, name: "f0f0"};
        tbl[2] = '{bits: 32'h0500_0000, nbits: 12, exp_trg: 5'b00010, name: "f050"};
        tbl[3] = '{bits: 32'h1FB0_0000, nbits: 12, exp_trg: 5'b10000, name: "f1fb"};
        tbl[4] = '{bits: 32'h1230_0000, nbits: 12, exp_trg: 5'b00000, name: "f123"};
        tbl[5] = '{bits: 32'hD800_0000, nbits: 7,  exp_trg: 5'b00000, name: "fd80_abort"};
        tbl[6] = '{bits: 32'hD800_0000, nbits: 12, exp_trg: 5'b00100, name: "fd80"};
        tbl[7] = '{bits: 32'h1300_0000, nbits: 12, exp_trg: 5'b01000, name: "f130"};

        clear_model();
        repeat (3) @(negedge CLK160M);
        check("rst_trg", TRG_PLS, 0);
        check("rst_cnt", HIT_CNT, 0);
        check("rst_cnt2", HIT_CNT2, 0);
        check("rst_busy", BUSY, 0);
        RESET_N = 1'b1;
        repeat (10) @(negedge CLK160M);

        for (int r = 0; r < 8; r++) begin
            if (tbl[r].exp_trg != '0) expect_pulse(tbl[r].exp_trg, 16);
            spi_frame(tbl[r].bits, tbl[r].nbits, 1'b1, 1'b0);
            settle_and_check(tbl[r].name);
        end

        // Unmatched frame parks in WAIT_CS until CS returns high
        spi_frame(32'h1230_0000, 12, 1'b0, 1'b0);
        repeat (20) @(negedge CLK160M);
        check("waitcs_busy_hi", BUSY, 1);
        SPI_CS = 1'b1;
        repeat (6) @(negedge CLK160M);
        check("waitcs_busy_lo", BUSY, 0);
        check("waitcs_pending", sb.size(), 0);

        // ch3 mask cleared: ch3 matches every frame, 2-bit counters saturate
        CFG_MASK[47:36] = 12'h000;
        w = 32'h1230_0000; expect_pulse(5'b01000, 16); spi_frame(w, 12, 1'b1, 1'b0); settle_and_check("any_123");
        w = 32'h1300_0000; expect_pulse(5'b01000, 16); spi_frame(w, 12, 1'b1, 1'b0); settle_and_check("any_130");
        w = 32'h1000_0000; expect_pulse(5'b01001, 16); spi_frame(w, 12, 1'b1, 1'b0); settle_and_check("any_100");
        w = 32'h0500_0000; expect_pulse(5'b01010, 16); spi_frame(w, 12, 1'b1, 1'b0); settle_and_check("any_050");
        w = 32'h1FB0_0000; expect_pulse(5'b11000, 16); spi_frame(w, 12, 1'b1, 1'b0); settle_and_check("any_1fb");
        check("sat_ch3_cnt2", HIT_CNT2[7:6], 2'd3);

        // CNT_CLR in the EVAL cycle beats the increment
        w = 32'h1000_0000;
        expect_pulse(5'b01001, 16);
        spi_frame(w, 12, 1'b1, 1'b1);
        clear_model();
        settle_and_check("clr_in_eval");

        // Reset during pulse cycle 5 with CS held low through release
        expect_pulse(5'b01001, 5);
        SPI_CS = 1'b0;
        repeat (4) @(negedge CLK160M);
        for (int i = 0; i < 12; i++) spi_bit(w[31-i], 1'b0);
        k = 0;
        while (TRG_PLS == '0 && k < 100) begin
            @(negedge CLK160M);
            k++;
        end
        check("rst_pulse_seen", (k < 100), 1);
        repeat (4) @(negedge CLK160M);
        #1 RESET_N = 1'b0;
        #1 check("rst_mid_trg", TRG_PLS, 0);
        clear_model();
        repeat (3) @(negedge CLK160M);
        RESET_N = 1'b1;
        repeat (10) @(negedge CLK160M);
        check("rst_release_busy", BUSY, 0);
        for (int i = 0; i < 12; i++) spi_bit(w[31-i], 1'b0);
        repeat (40) @(negedge CLK160M);
        check("stale_frame_busy", BUSY, 0);
        check("stale_frame_cnt", HIT_CNT, 0);
        check("stale_frame_pending", sb.size(), 0);
        SPI_CS = 1'b1;
        repeat (10) @(negedge CLK160M);
        expect_pulse(5'b01001, 16);
        spi_frame(w, 12, 1'b1, 1'b0);
        settle_and_check("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
